// File: rtl/zbus_pkg.sv
// Shared zbus definitions: the transfer condition, FIFO geometry check and a
// bench fill constant for idle payloads.
package zbus_pkg;

  // Fill value for payload bits that carry no meaning (idle bus).
  localparam logic ZBUS_XZ = 1'bx;

  // A zbus transfer happens on a side whenever valid and acknowledge coincide.
  function automatic logic zbus_xfer(input logic vld, input logic ack);
    return vld & ack;
  endfunction

  // Geometry is legal when depth is a power of two >= 2 and aw addresses it exactly.
  function automatic bit zbus_depth_ok(input int depth, input int aw);
    return (depth >= 2) && (aw >= 1) && (aw < 31) && (depth == (1 << aw));
  endfunction

endpackage

// File: rtl/zbus_fifo_mem.sv
// DEPTH x BW register array for zbus_fifo: one synchronous write port and one
// asynchronous read port.
module zbus_fifo_mem #(
  parameter int BW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          z_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  logic [BW-1:0] mem [DEPTH];

  // NOTE: storage has no reset on purpose; occupancy is tracked by the pointers
  // and counter, so stale entries are never presented and a reset here would only
  // cost flops' reset routing.
  always_ff @(posedge z_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/zbus_fifo.sv
// Synchronous zbus FIFO between a zbus producer (zi_*) and consumer (zo_*).
// Optional ZBUS_FIFO_BYPASS_EN adds a zero-latency pass-through when empty.
module zbus_fifo
  import zbus_pkg::*;
#(
  parameter int BW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          z_clk,
  input  logic          z_rst_n,
  input  logic          zi_vld,
  input  logic [BW-1:0] zi_bus,
  output logic          zi_ack,
  output logic          zo_vld,
  output logic [BW-1:0] zo_bus,
  input  logic          zo_ack,
  output logic [AW:0]   z_cnt
);

  if (!zbus_depth_ok(DEPTH, AW)) begin : g_bad_cfg
    $error("zbus_fifo: DEPTH must be a power of two >= 2 and equal to 2**AW");
  end

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [BW-1:0] rdata;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty  = (cnt == '0);
  // Acceptance depends only on registered occupancy, so no ack path crosses the block.
  assign zi_ack = (cnt != CNT_FULL);
  assign z_cnt  = cnt;

`ifdef ZBUS_FIFO_BYPASS_EN
  logic byp_pass;

  // An empty FIFO forwards the incoming word; if it is taken now it is never stored.
  assign byp_pass = empty & zi_vld & zo_ack;
  assign zo_vld   = ~empty | zi_vld;
  assign zo_bus   = empty ? zi_bus : rdata;
  assign push     = zbus_xfer(zi_vld, zi_ack) & ~byp_pass;
  assign pop      = zbus_xfer(zo_vld, zo_ack) & ~empty;
`else
  assign zo_vld   = ~empty;
  assign zo_bus   = rdata;
  assign push     = zbus_xfer(zi_vld, zi_ack);
  assign pop      = zbus_xfer(zo_vld, zo_ack);
`endif

  zbus_fifo_mem #(
    .BW    (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .z_clk (z_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (zi_bus),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge z_clk or negedge z_rst_n) begin
    if (!z_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_zbus_fifo.sv
// Self-checking bench for zbus_fifo: directed scenarios plus a random stream,
// checked by a queue scoreboard in a decoupled monitor.
module tb_zbus_fifo;
  import zbus_pkg::*;

  localparam int BW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef ZBUS_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          z_clk = 1'b0;
  logic          z_rst_n = 1'b0;
  logic          zi_vld = 1'b0;
  logic [BW-1:0] zi_bus = '0;
  logic          zi_ack;
  logic          zo_vld;
  logic [BW-1:0] zo_bus;
  logic          zo_ack = 1'b0;
  logic [AW:0]   z_cnt;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  logic [BW-1:0] model_q[$];

  zbus_fifo #(.BW(BW), .DEPTH(DEPTH), .AW(AW)) dut (
    .z_clk   (z_clk),
    .z_rst_n (z_rst_n),
    .zi_vld  (zi_vld),
    .zi_bus  (zi_bus),
    .zi_ack  (zi_ack),
    .zo_vld  (zo_vld),
    .zo_bus  (zo_bus),
    .zo_ack  (zo_ack),
    .z_cnt   (z_cnt)
  );

  always #5 z_clk = ~z_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge z_clk);
    #1;
  endtask

  task automatic idle_in();
    zi_vld = 1'b0;
    zi_bus = {BW{ZBUS_XZ}};
  endtask

  task automatic do_reset();
    z_rst_n = 1'b0;
    idle_in();
    zo_ack = 1'b0;
    #1;
    check("rst_cnt", z_cnt, 0);
    check("rst_zo_vld", zo_vld, 0);
    check("rst_zi_ack", zi_ack, 1);
    cycle();
    cycle();
    #2 z_rst_n = 1'b1;
    cycle();
  endtask

  // Scoreboard monitor: the model is an ordered queue of accepted words.
  always @(negedge z_clk) begin
    if (!z_rst_n) begin
      model_q.delete();
    end else begin
      check("mon_cnt", z_cnt, model_q.size());
      check("mon_zi_ack", zi_ack, model_q.size() != DEPTH);
      check("mon_zo_vld", zo_vld, (model_q.size() != 0) || (BYP && zi_vld));
      if (zo_vld && model_q.size() != 0) check("mon_head", zo_bus, model_q[0]);
      if (zi_vld && zi_ack) model_q.push_back(zi_bus);
      if (zo_vld && zo_ack) begin
        vectors++;
        if (model_q.size() == 0) begin
          miscompares++;
          $display("FAIL mon_pop_empty: got a pop with model empty at %0t", $time);
        end else begin
          logic [BW-1:0] exp;
          exp = model_q.pop_front();
          pops++;
          if (zo_bus !== exp) begin
            miscompares++;
            $display("FAIL mon_pop_data: got %0h expected %0h at %0t", zo_bus, exp, $time);
          end
        end
      end
    end
  end

  initial begin
    int base;
    int n;

    // 1: three pushes without draining
    do_reset();
    foreach (model_q[i]) ;
    for (int i = 0; i < 3; i++) begin
      zi_vld = 1'b1;
      zi_bus = BW'(8'h11 * (i + 1));
      cycle();
    end
    idle_in();
    check("t1_cnt", z_cnt, 3);
    check("t1_zo_vld", zo_vld, 1);
    check("t1_zo_bus", zo_bus, 8'h11);
    check("t1_zi_ack", zi_ack, 1);

    // 2: full, held push, pop frees a slot only on the following cycle
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      zi_vld = 1'b1;
      zi_bus = BW'(i);
      cycle();
    end
    check("t2_full_cnt", z_cnt, 4);
    check("t2_full_ack", zi_ack, 0);
    zi_bus = 8'h05;
    cycle();
    check("t2_held_cnt", z_cnt, 4);
    zo_ack = 1'b1;
    cycle();
    zo_ack = 1'b0;
    check("t2_after_pop_cnt", z_cnt, 3);
    check("t2_after_pop_ack", zi_ack, 1);
    cycle();
    idle_in();
    check("t2_refill_cnt", z_cnt, 4);
    zo_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_pop_val", zo_bus, 32'h02 + i);
      cycle();
    end
    zo_ack = 1'b0;
    check("t2_drained_cnt", z_cnt, 0);

    // 3: steady stream, 16 values, push and pop every cycle
    do_reset();
    base = pops;
    zo_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      zi_vld = 1'b1;
      zi_bus = BW'(i);
      cycle();
      check("t3_steady_cnt", z_cnt, BYP ? 0 : 1);
    end
    idle_in();
    cycle();
    check("t3_pop_total", pops - base, 16);
    check("t3_end_cnt", z_cnt, 0);
    zo_ack = 1'b0;

    // 4: single push into an empty FIFO with the consumer ready
    do_reset();
    zo_ack = 1'b1;
    zi_vld = 1'b1;
    zi_bus = 8'hA5;
    #1;
    check("t4_same_cycle_vld", zo_vld, BYP);
    cycle();
    idle_in();
    check("t4_cnt", z_cnt, BYP ? 0 : 1);
    check("t4_next_cycle", {zo_vld, zo_vld ? zo_bus : 8'h00}, BYP ? 9'h000 : 9'h1A5);
    cycle();
    zo_ack = 1'b0;
    check("t4_end_cnt", z_cnt, 0);

    // 5: reset mid-burst drops everything
    do_reset();
    for (int i = 0; i < 3; i++) begin
      zi_vld = 1'b1;
      zi_bus = BW'(8'h30 + i);
      cycle();
    end
    zi_bus = 8'h44;
    #3;
    z_rst_n = 1'b0;
    idle_in();
    #1;
    check("t5_rst_cnt", z_cnt, 0);
    check("t5_rst_vld", zo_vld, 0);
    check("t5_rst_ack", zi_ack, 1);
    cycle();
    cycle();
    #2 z_rst_n = 1'b1;
    cycle();
    zi_vld = 1'b1;
    zi_bus = 8'h7E;
    cycle();
    idle_in();
    check("t5_cnt", z_cnt, 1);
    check("t5_head", zo_bus, 8'h7E);
    zo_ack = 1'b1;
    cycle();
    zo_ack = 1'b0;
    check("t5_end_cnt", z_cnt, 0);

    // 6: random traffic, 1000 output transfers
    do_reset();
    base = pops;
    n = 0;
    while ((pops - base) < 1000 && n < 20000) begin
      zi_vld = 1'($urandom_range(0, 1));
      zi_bus = BW'($urandom);
      zo_ack = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    idle_in();
    zo_ack = 1'b0;
    check("t6_completed", (pops - base) >= 1000, 1);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
